// File: rtl/joy_pkg.sv
// Shared types and constants for the DB15 joystick serial responder.
package joy_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, LOADED, SHIFT} joy_state_e;

    localparam int JOY_W = 12;

    localparam int JOY_RIGHT = 0;
    localparam int JOY_LEFT  = 1;
    localparam int JOY_DOWN  = 2;
    localparam int JOY_UP    = 3;
    localparam int JOY_BTN0  = 4;
endpackage

// File: rtl/joy_sync_edge.sv
// Two-flop synchronizer plus registered rise detect for one host line.
// JOY_DB15_TX_FILTER_EN inserts a 3-sample majority filter after the synchronizer.
module joy_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic lvl,
    output logic rise
);
    logic s1, s2, filt;

`ifdef JOY_DB15_TX_FILTER_EN
    logic [2:0] hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist <= 3'b111;
        else        hist <= {hist[1:0], s2};
    end

    assign filt = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
`else
    assign filt = s2;
`endif

    // Lines idle high, so everything resets to 1 and no spurious edge follows reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            lvl  <= 1'b1;
            rise <= 1'b0;
        end else begin
            s1   <= din;
            s2   <= s1;
            lvl  <= filt;
            rise <= filt & ~lvl;
        end
    end
endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick adapter: parallel-load two player words on joy_load, shift out on joy_clk.
// Optional glitch filter on the host lines via JOY_DB15_TX_FILTER_EN.
module joy_db15_tx
    import joy_pkg::*;
#(
    parameter int NBITS   = 24,
    parameter int TIMEOUT = 4096
) (
    input  logic             clk,
    input  logic             Reset_n,
    input  logic [JOY_W-1:0] joystick1,
    input  logic [JOY_W-1:0] joystick2,
    input  logic             joy_load,
    input  logic             joy_clk,
    output logic             joy_data,
    output logic             frame_done,
    output logic             busy
);
    localparam int CNT_W  = $clog2(NBITS + 1);
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    joy_state_e        state, state_n;
    logic [NBITS-1:0]  sr, sr_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [IDLE_W-1:0] idle_cnt, idle_n;
    logic              done_n;
    logic              ld_lvl, ld_rise, ck_lvl, ck_rise;

    joy_sync_edge u_load (.clk(clk), .rst_n(Reset_n), .din(joy_load), .lvl(ld_lvl), .rise(ld_rise));
    joy_sync_edge u_clk  (.clk(clk), .rst_n(Reset_n), .din(joy_clk),  .lvl(ck_lvl), .rise(ck_rise));

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            sr         <= '1;
            cnt        <= '0;
            idle_cnt   <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            sr         <= sr_n;
            cnt        <= cnt_n;
            idle_cnt   <= idle_n;
            frame_done <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        idle_n  = idle_cnt;
        done_n  = 1'b0;
        // Load outranks everything, including a shift edge in the same cycle.
        if (!ld_lvl) begin
            state_n = LOAD;
            sr_n    = ~NBITS'({joystick2, joystick1});
            cnt_n   = '0;
            idle_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    sr_n   = '1;
                    cnt_n  = '0;
                    idle_n = '0;
                end
                LOAD: begin
                    state_n = LOADED;
                    idle_n  = '0;
                end
                LOADED, SHIFT: begin
                    if (ck_rise) begin
                        sr_n   = {1'b1, sr[NBITS-1:1]};
                        cnt_n  = cnt + 1'b1;
                        idle_n = '0;
                        state_n = SHIFT;
                        if (cnt_n == CNT_W'(NBITS)) begin
                            state_n = IDLE;
                            sr_n    = '1;
                            cnt_n   = '0;
                            done_n  = 1'b1;
                        end
                    end else if (idle_cnt == IDLE_W'(TIMEOUT)) begin
                        state_n = IDLE;
                        sr_n    = '1;
                        cnt_n   = '0;
                        idle_n  = '0;
                    end else begin
                        idle_n = idle_cnt + 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    assign joy_data = (state == IDLE) ? 1'b1 : sr[0];
    assign busy     = (state != IDLE);

    // The level outputs are only needed for load priority; tie off the clock one.
    logic unused_ok;
    assign unused_ok = ck_lvl ^ ld_rise;
endmodule

// File: tb/tb_joy_db15_tx.sv
// Randomized bench for joy_db15_tx against a frame-level model (bit array + position).
module tb_joy_db15_tx;
    localparam int NBITS   = 24;
    localparam int TIMEOUT = 4096;

    logic        clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [11:0] joystick1 = '0;
    logic [11:0] joystick2 = '0;
    logic        joy_load = 1'b1;
    logic        joy_clk  = 1'b0;
    logic        joy_data, frame_done, busy;

    always #10 clk = ~clk;

    joy_db15_tx #(.NBITS(NBITS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .Reset_n(Reset_n), .joystick1(joystick1), .joystick2(joystick2),
        .joy_load(joy_load), .joy_clk(joy_clk), .joy_data(joy_data),
        .frame_done(frame_done), .busy(busy)
    );

    int checks = 0, errors = 0;
    int done_seen = 0, done_exp = 0;
    bit settled = 0;

    // Model: the captured frame as a bit array and the index of the bit on the wire.
    bit m_active = 0;
    int m_pos = 0;
    bit m_bits[NBITS];

    function automatic bit m_data();
        return m_active ? m_bits[m_pos] : 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (frame_done === 1'b1) done_seen++;
        if (settled) begin
            chk("joy_data", {31'd0, joy_data}, {31'd0, m_data()});
            chk("busy", {31'd0, busy}, {31'd0, m_active});
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_rise();
        if (m_active) begin
            m_pos++;
            if (m_pos == NBITS) begin
                m_active = 0;
                m_pos    = 0;
                done_exp++;
            end
        end
    endtask

    task automatic do_load();
        logic [23:0] w;
        settled  = 0;
        joy_load = 1'b0;
        step(8 + $urandom_range(0, 3));
        joy_load = 1'b1;
        w = ~{joystick2, joystick1};
        for (int i = 0; i < NBITS; i++) m_bits[i] = w[i];
        step(8);
        m_active = 1;
        m_pos    = 0;
        settled  = 1;
    endtask

    task automatic do_rise();
        settled = 0;
        joy_clk = 1'b1;
        step(8 + $urandom_range(0, 3));
        model_rise();
        settled = 1;
        joy_clk = 1'b0;
        step(7 + $urandom_range(0, 3));
    endtask

    logic [23:0] exp_stream;
    int          d0;

    initial begin
        // Reset state
        step(3);
        chk("rst_joy_data", {31'd0, joy_data}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        Reset_n = 1'b1;
        step(5);
        settled = 1;

        // Full frame with the hand-derived bit stream
        joystick1 = 12'h011;
        joystick2 = 12'h800;
        exp_stream = 24'h7FFFEE;
        d0 = done_seen;
        do_load();
        for (int k = 0; k < NBITS; k++) begin
            chk("stream_bit", {31'd0, joy_data}, {31'd0, exp_stream[k]});
            do_rise();
        end
        chk("frame_done_once", done_seen - d0, 32'd1);
        chk("end_joy_data", {31'd0, joy_data}, 32'd1);
        chk("end_busy", {31'd0, busy}, 32'd0);

        // Load abort after 10 shifts
        joystick1 = 12'h5A5;
        joystick2 = 12'h3C3;
        d0 = done_seen;
        do_load();
        repeat (10) do_rise();
        joystick1 = 12'h002;
        joystick2 = 12'h000;
        do_load();
        chk("abort_bit0", {31'd0, joy_data}, 32'd1);
        do_rise();
        chk("abort_bit1", {31'd0, joy_data}, 32'd0);
        chk("abort_no_done", done_seen - d0, 32'd0);

        // Timeout
        joystick1 = 12'hFFF;
        joystick2 = 12'h0F0;
        d0 = done_seen;
        do_load();
        repeat (5) do_rise();
        settled = 0;
        step(TIMEOUT + 10);
        m_active = 0;
        m_pos    = 0;
        settled  = 1;
        step(2);
        chk("timeout_joy_data", {31'd0, joy_data}, 32'd1);
        chk("timeout_busy", {31'd0, busy}, 32'd0);
        chk("timeout_no_done", done_seen - d0, 32'd0);

        // Extra clocks
        joystick1 = 12'h000;
        joystick2 = 12'hFFF;
        d0 = done_seen;
        do_load();
        for (int k = 1; k <= 30; k++) begin
            do_rise();
            if (k >= 25) chk("extra_joy_data", {31'd0, joy_data}, 32'd1);
        end
        chk("extra_one_done", done_seen - d0, 32'd1);

        // Single-cycle glitch on joy_clk during a shift
        joystick1 = 12'h0AA;
        joystick2 = 12'h555;
        do_load();
        repeat (3) do_rise();
        settled = 0;
        joy_clk = 1'b1;
        step(1);
        joy_clk = 1'b0;
        step(12);
`ifndef JOY_DB15_TX_FILTER_EN
        model_rise();
`endif
        settled = 1;
        step(2);
        chk("glitch_joy_data", {31'd0, joy_data}, {31'd0, m_data()});
        repeat (2) do_rise();

        // Randomized frames, some reloaded mid-way
        for (int f = 0; f < 8; f++) begin
            joystick1 = 12'($urandom);
            joystick2 = 12'($urandom);
            do_load();
            for (int r = $urandom_range(0, 30); r > 0; r--) do_rise();
        end
        chk("rand_done_count", done_seen, done_exp);

        // Asynchronous reset in the middle of a shift
        joystick1 = 12'h000;
        joystick2 = 12'h000;
        do_load();
        repeat (6) do_rise();
        d0 = done_seen;
        settled = 0;
        @(posedge clk);
        #3;
        Reset_n = 1'b0;
        #1;
        chk("arst_joy_data", {31'd0, joy_data}, 32'd1);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        m_active = 0;
        m_pos    = 0;
        step(3);
        Reset_n = 1'b1;
        step(6);
        settled = 1;
        repeat (3) do_rise();
        chk("arst_no_done", done_seen - d0, 32'd0);
        chk("final_done_count", done_seen, done_exp);

        settled = 0;
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
